// File: rtl/cpu_pkg.sv
// cpu_pkg
// Definitions shared by the CPU top, the instruction RAM and the boot-time
// program loader: the default instruction word and RAM address widths, the
// loader state encoding, and a helper that derives bytes-per-word.
// No ports (package).

package cpu_pkg;

   localparam int INSTR_W_DEF = 32;
   localparam int ADDR_W_DEF  = 8;

   // CHK is part of the shared encoding even when the checksum stage is
   // compiled out, so every build agrees on the state numbering.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HDR   = 3'd1,
      DATA  = 3'd2,
      WRITE = 3'd3,
      CHK   = 3'd4,
      DONE  = 3'd5,
      ERR   = 3'd6
   } loaderState_t;

   function automatic int bytesPerWord(input int instrW);
      return instrW / 8;
   endfunction

endpackage

// File: rtl/program_loader_word_assembler.sv
// word_assembler
// Shifts incoming bytes MSB-first into an instruction word and flags the
// byte that completes the word.
// Ports:
//   i_clk       system clock, rising edge
//   i_pc_reset  synchronous active-high reset
//   i_clear     synchronous clear of word and byte counter (new load/header)
//   i_shift     accept i_byte this cycle
//   i_byte      incoming byte
//   o_word      assembled word (holds after completion until the next shift)
//   o_wordValid high in the cycle the BPW-th byte of a word is being accepted

module word_assembler
   import cpu_pkg::*;
#(
   parameter int INSTR_W = INSTR_W_DEF
) (
   input  logic               i_clk,
   input  logic               i_pc_reset,
   input  logic               i_clear,
   input  logic               i_shift,
   input  logic [7:0]         i_byte,
   output logic [INSTR_W-1:0] o_word,
   output logic               o_wordValid
);

   localparam int BPW   = bytesPerWord(INSTR_W);
   localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

   logic [CNT_W-1:0]   r_byteCount;
   logic [INSTR_W-1:0] r_word;

   // The completing byte is recognised combinationally so the FSM can move
   // to WRITE on the same edge that stores it.
   always_comb begin
      o_wordValid = i_shift && (r_byteCount == CNT_W'(BPW - 1));
   end

   // Shift left by a byte so the first byte received ends up most significant;
   // the counter rolls back to zero once a word is complete.
   always_ff @(posedge i_clk) begin
      if (i_pc_reset || i_clear) begin
         r_word      <= '0;
         r_byteCount <= '0;
      end else if (i_shift) begin
         r_word <= (r_word << 8) | INSTR_W'(i_byte);
         if (o_wordValid) begin
            r_byteCount <= '0;
         end else begin
            r_byteCount <= r_byteCount + 1'b1;
         end
      end
   end

   assign o_word = r_word;

endmodule

// File: rtl/program_loader.sv
// program_loader
// Boot-time loader in front of the CPU top. Receives a byte stream
// (header N, then N words MSB-first, then optionally a checksum byte),
// writes the words to instruction RAM from address 0 and releases the CPU
// (o_cpu_run) once the image is complete.
// Optional feature: define CHECKSUM_EN to require a trailing XOR checksum
// byte covering every accepted byte including the header.
// Ports:
//   i_clk        system clock, rising edge
//   i_pc_reset   synchronous active-high reset
//   i_start      single-cycle pulse starting a load (ignored while busy)
//   i_in_valid   input byte valid
//   i_in_data    input byte
//   o_in_ready   a byte can be accepted this cycle
//   o_mem_we     instruction RAM write strobe, one cycle per word
//   o_mem_addr   instruction RAM write address
//   o_mem_wdata  instruction word to write
//   o_cpu_run    CPU released to execute
//   o_busy       load in progress
//   o_done       sticky, load completed
//   o_error      sticky, load aborted on a format error

module program_loader
   import cpu_pkg::*;
#(
   parameter int INSTR_W = INSTR_W_DEF,
   parameter int ADDR_W  = ADDR_W_DEF
) (
   input  logic               i_clk,
   input  logic               i_pc_reset,
   input  logic               i_start,
   input  logic               i_in_valid,
   input  logic [7:0]         i_in_data,
   output logic               o_in_ready,
   output logic               o_mem_we,
   output logic [ADDR_W-1:0]  o_mem_addr,
   output logic [INSTR_W-1:0] o_mem_wdata,
   output logic               o_cpu_run,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_error
);

   localparam logic [31:0] DEPTH = 32'd1 << ADDR_W;

   loaderState_t       r_state;
   loaderState_t       w_nextState;
   logic [7:0]         r_wordCount;
   logic [ADDR_W-1:0]  r_addr;
   logic               w_transfer;
   logic               w_startAccepted;
   logic               w_badCount;
   logic               w_lastWord;
   logic               w_shift;
   logic               w_clearAsm;
   logic               w_wordValid;
   logic [INSTR_W-1:0] w_word;
`ifdef CHECKSUM_EN
   logic [7:0]         r_xor;
`endif

   // Handshake qualifiers and header sanity. The depth test is done in 32
   // bits so a count equal to the full RAM depth is still legal.
   always_comb begin
      w_transfer      = i_in_valid && o_in_ready;
      w_startAccepted = i_start && ((r_state == IDLE) || (r_state == DONE) || (r_state == ERR));
      w_badCount      = (i_in_data == 8'd0) || ({24'd0, i_in_data} > DEPTH);
      w_lastWord      = (32'(r_addr) + 32'd1) == {24'd0, r_wordCount};
      w_shift         = (r_state == DATA) && w_transfer;
      w_clearAsm      = w_startAccepted || ((r_state == HDR) && w_transfer);
   end

   word_assembler #(
      .INSTR_W (INSTR_W)
   ) u_wordAssembler (
      .i_clk       (i_clk),
      .i_pc_reset  (i_pc_reset),
      .i_clear     (w_clearAsm),
      .i_shift     (w_shift),
      .i_byte      (i_in_data),
      .o_word      (w_word),
      .o_wordValid (w_wordValid)
   );

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_pc_reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state and Moore outputs. done/error/cpu_run are sticky simply by
   // staying in DONE/ERR; leaving either (reset or start) drops them.
   always_comb begin
      w_nextState = r_state;
      o_in_ready  = 1'b0;
      o_mem_we    = 1'b0;
      o_busy      = 1'b0;
      o_done      = 1'b0;
      o_error     = 1'b0;
      o_cpu_run   = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_start) w_nextState = HDR;
         end
         HDR: begin
            o_in_ready = 1'b1;
            o_busy     = 1'b1;
            if (w_transfer) w_nextState = w_badCount ? ERR : DATA;
         end
         DATA: begin
            o_in_ready = 1'b1;
            o_busy     = 1'b1;
            if (w_wordValid) w_nextState = WRITE;
         end
         WRITE: begin
            o_mem_we = 1'b1;
            o_busy   = 1'b1;
            if (w_lastWord) begin
`ifdef CHECKSUM_EN
               w_nextState = CHK;
`else
               w_nextState = DONE;
`endif
            end else begin
               w_nextState = DATA;
            end
         end
`ifdef CHECKSUM_EN
         CHK: begin
            o_in_ready = 1'b1;
            o_busy     = 1'b1;
            if (w_transfer) w_nextState = (i_in_data == r_xor) ? DONE : ERR;
         end
`endif
         DONE: begin
            o_done    = 1'b1;
            o_cpu_run = 1'b1;
            if (i_start) w_nextState = HDR;
         end
         ERR: begin
            o_error = 1'b1;
            if (i_start) w_nextState = HDR;
         end
         default: w_nextState = IDLE;
      endcase
   end

   // Word count and write address. A new load restarts at address 0; the
   // address advances after every write, so it points at the next free slot.
   always_ff @(posedge i_clk) begin
      if (i_pc_reset) begin
         r_wordCount <= '0;
         r_addr      <= '0;
      end else begin
         if (w_startAccepted) begin
            r_addr <= '0;
         end else if (r_state == WRITE) begin
            r_addr <= r_addr + 1'b1;
         end
         if ((r_state == HDR) && w_transfer) begin
            r_wordCount <= i_in_data;
         end
      end
   end

`ifdef CHECKSUM_EN
   // Running XOR over every accepted byte from the header onwards; in CHK it
   // is compared before the checksum byte itself is folded in.
   always_ff @(posedge i_clk) begin
      if (i_pc_reset || w_startAccepted) begin
         r_xor <= '0;
      end else if (w_transfer) begin
         r_xor <= r_xor ^ i_in_data;
      end
   end
`endif

   assign o_mem_addr  = r_addr;
   assign o_mem_wdata = w_word;

endmodule
